farc_as_result_stage: RTL and testbench

FARC_AS_RESULT_STAGE -- requirements
Module: farc_as_result_stage

---
 rtl/farc_as_pkg.sv | 13 +
 rtl/farc_2c2sm.sv | 30 +++
 rtl/farc_as_result_stage.sv | 140 ++++++++++++++
 tb/tb_farc_as_result_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/farc_as_pkg.sv
// Shared definitions for the adder/subtractor result stage: skid-buffer
// state encoding and statistics counter width.
package farc_as_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } fifo_state_t;

  localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/farc_2c2sm.sv
// Combinational 2's complement to sign-magnitude converter. The most negative
// value has no sign-magnitude encoding and saturates to all ones.
module farc_2c2sm #(
  parameter int ADDER_WIDTH = 32
) (
  input  logic [ADDER_WIDTH-1:0] in_sum,
  output logic [ADDER_WIDTH-1:0] sm_result,
  output logic                   sat
);

  localparam logic [ADDER_WIDTH-1:0] MIN_NEG = {1'b1, {(ADDER_WIDTH-1){1'b0}}};

  // Low bits of (~in_sum + 1); the dropped top bit is never needed.
  logic [ADDER_WIDTH-2:0] magnitude;

  assign magnitude = ~in_sum[ADDER_WIDTH-2:0] + (ADDER_WIDTH-1)'(1);
  assign sat       = (in_sum == MIN_NEG);

  // Only MIN_NEG yields a zero magnitude with the sign set, so saturating it
  // also rules out negative zero.
  always_comb begin
    sm_result = in_sum;
    if (sat) begin
      sm_result = '1;
    end else if (in_sum[ADDER_WIDTH-1]) begin
      sm_result = {1'b1, magnitude};
    end
  end

endmodule

// File: rtl/farc_as_result_stage.sv
// Adder result stage: overflow detection and optional sign-magnitude
// formatting, followed by a 2-entry skid buffer and delivery statistics.
module farc_as_result_stage
  import farc_as_pkg::*;
#(
  parameter int ADDER_WIDTH = 32,
  parameter int SM2C        = 1
) (
  input  logic                   ip_clk,
  input  logic                   ip_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] in_sum,
  input  logic                   in_a_msb,
  input  logic                   in_b_msb,
  input  logic                   in_addsub_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] out_result,
  output logic                   out_ovf,
  input  logic                   cnt_clr,
  output logic [CNT_WIDTH-1:0]   res_cnt,
  output logic [CNT_WIDTH-1:0]   ovf_cnt
);

  localparam int MSB = ADDER_WIDTH - 1;

  fifo_state_t            state_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic [ADDER_WIDTH-1:0] head_data_reg;
  logic                   head_ovf_reg;
  logic [ADDER_WIDTH-1:0] tail_data_reg;
  logic                   tail_ovf_reg;
  logic [CNT_WIDTH-1:0]   res_cnt_reg;
  logic [CNT_WIDTH-1:0]   ovf_cnt_reg;

  logic [ADDER_WIDTH-1:0] fmt_data;
  logic                   fmt_sat;
  logic                   signed_ovf;
  logic                   fmt_ovf;
  logic                   push;
  logic                   pop;

  generate
    if (SM2C != 0) begin : g_sm
      farc_2c2sm #(
        .ADDER_WIDTH(ADDER_WIDTH)
      ) u_2c2sm (
        .in_sum   (in_sum),
        .sm_result(fmt_data),
        .sat      (fmt_sat)
      );
    end else begin : g_2c
      assign fmt_data = in_sum;
      assign fmt_sat  = 1'b0;
    end
  endgenerate

  // Operands of equal effective sign whose sum flips sign have overflowed.
  assign signed_ovf = (in_a_msb == (in_b_msb ^ in_addsub_sel)) && (in_sum[MSB] != in_a_msb);
  assign fmt_ovf    = signed_ovf | fmt_sat;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  // Head slot always holds the oldest entry and drives the outputs directly.
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      head_data_reg <= '0;
      head_ovf_reg  <= 1'b0;
      tail_data_reg <= '0;
      tail_ovf_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          in_ready_reg <= 1'b1;
          if (push) begin
            head_data_reg <= fmt_data;
            head_ovf_reg  <= fmt_ovf;
            state_reg     <= ST_ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_data_reg <= fmt_data;
            head_ovf_reg  <= fmt_ovf;
          end else if (push) begin
            tail_data_reg <= fmt_data;
            tail_ovf_reg  <= fmt_ovf;
            state_reg     <= ST_FULL;
            in_ready_reg  <= 1'b0;
          end else if (pop) begin
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_data_reg <= tail_data_reg;
            head_ovf_reg  <= tail_ovf_reg;
            state_reg     <= ST_ONE;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst || cnt_clr) begin
      res_cnt_reg <= '0;
      ovf_cnt_reg <= '0;
    end else if (pop) begin
      if (res_cnt_reg != '1) begin
        res_cnt_reg <= res_cnt_reg + 1'b1;
      end
      if (head_ovf_reg && (ovf_cnt_reg != '1)) begin
        ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = head_data_reg;
  assign out_ovf    = head_ovf_reg;
  assign res_cnt    = res_cnt_reg;
  assign ovf_cnt    = ovf_cnt_reg;

endmodule

// File: tb/tb_farc_as_result_stage.sv
// Directed bench for farc_as_result_stage: one sign-magnitude instance and
// one 2's complement pass-through instance driven by the same stimulus.
module tb_farc_as_result_stage;

  logic        tb_ip_clk;
  logic        tb_ip_rst;
  logic        in_valid;
  logic [31:0] in_sum;
  logic        in_a_msb;
  logic        in_b_msb;
  logic        in_addsub_sel;
  logic        out_ready;
  logic        cnt_clr;

  logic        sm_in_ready,  tc_in_ready;
  logic        sm_out_valid, tc_out_valid;
  logic [31:0] sm_out_result, tc_out_result;
  logic        sm_out_ovf,   tc_out_ovf;
  logic [15:0] sm_res_cnt,   tc_res_cnt;
  logic [15:0] sm_ovf_cnt,   tc_ovf_cnt;

  int checks = 0;
  int errors = 0;

  farc_as_result_stage #(.ADDER_WIDTH(32), .SM2C(1)) dut (
    .ip_clk       (tb_ip_clk),
    .ip_rst       (tb_ip_rst),
    .in_valid     (in_valid),
    .in_ready     (sm_in_ready),
    .in_sum       (in_sum),
    .in_a_msb     (in_a_msb),
    .in_b_msb     (in_b_msb),
    .in_addsub_sel(in_addsub_sel),
    .out_valid    (sm_out_valid),
    .out_ready    (out_ready),
    .out_result   (sm_out_result),
    .out_ovf      (sm_out_ovf),
    .cnt_clr      (cnt_clr),
    .res_cnt      (sm_res_cnt),
    .ovf_cnt      (sm_ovf_cnt)
  );

  farc_as_result_stage #(.ADDER_WIDTH(32), .SM2C(0)) dut_tc (
    .ip_clk       (tb_ip_clk),
    .ip_rst       (tb_ip_rst),
    .in_valid     (in_valid),
    .in_ready     (tc_in_ready),
    .in_sum       (in_sum),
    .in_a_msb     (in_a_msb),
    .in_b_msb     (in_b_msb),
    .in_addsub_sel(in_addsub_sel),
    .out_valid    (tc_out_valid),
    .out_ready    (out_ready),
    .out_result   (tc_out_result),
    .out_ovf      (tc_out_ovf),
    .cnt_clr      (cnt_clr),
    .res_cnt      (tc_res_cnt),
    .ovf_cnt      (tc_ovf_cnt)
  );

  initial tb_ip_clk = 1'b0;
  always #5 tb_ip_clk = ~tb_ip_clk;

  task automatic tick();
    @(posedge tb_ip_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    tb_ip_rst     = 1'b1;
    in_valid      = 1'b0;
    in_sum        = '0;
    in_a_msb      = 1'b0;
    in_b_msb      = 1'b0;
    in_addsub_sel = 1'b0;
    out_ready     = 1'b0;
    cnt_clr       = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {31'd0, sm_in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, sm_out_valid}, 32'd0);
    chk("rst_out_result", sm_out_result, 32'd0);
    chk("rst_out_ovf", {31'd0, sm_out_ovf}, 32'd0);
    chk("rst_res_cnt", {16'd0, sm_res_cnt}, 32'd0);
    chk("rst_ovf_cnt", {16'd0, sm_ovf_cnt}, 32'd0);
    tb_ip_rst = 1'b0;
    tick();
    chk("rel_in_ready", {31'd0, sm_in_ready}, 32'd1);
    $display("reset released: in_ready=%0d", sm_in_ready);

    // -2 from 0 - 2: sign-magnitude 0x80000002, no overflow
    in_valid = 1'b1; in_sum = 32'hFFFF_FFFE; in_a_msb = 1'b0; in_b_msb = 1'b0;
    in_addsub_sel = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("neg2_valid", {31'd0, sm_out_valid}, 32'd1);
    chk("neg2_result", sm_out_result, 32'h8000_0002);
    chk("neg2_ovf", {31'd0, sm_out_ovf}, 32'd0);
    chk("neg2_tc_result", tc_out_result, 32'hFFFF_FFFE);
    $display("txn sum=fffffffe sm=%08h ovf=%0d", sm_out_result, sm_out_ovf);
    tick();
    chk("neg2_res_cnt", {16'd0, sm_res_cnt}, 32'd1);
    chk("neg2_empty", {31'd0, sm_out_valid}, 32'd0);

    // 0x7FFFFFFF + 1: overflow, most-negative value saturates in sign-magnitude
    in_valid = 1'b1; in_sum = 32'h8000_0000; in_a_msb = 1'b0; in_b_msb = 1'b0;
    in_addsub_sel = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("sat_result", sm_out_result, 32'hFFFF_FFFF);
    chk("sat_ovf", {31'd0, sm_out_ovf}, 32'd1);
    chk("sat_tc_result", tc_out_result, 32'h8000_0000);
    chk("sat_tc_ovf", {31'd0, tc_out_ovf}, 32'd1);
    $display("txn sum=80000000 sm=%08h tc=%08h ovf=%0d/%0d", sm_out_result, tc_out_result, sm_out_ovf, tc_out_ovf);
    tick();
    chk("sat_ovf_cnt", {16'd0, sm_ovf_cnt}, 32'd1);
    chk("sat_res_cnt", {16'd0, sm_res_cnt}, 32'd2);
    chk("sat_tc_ovf_cnt", {16'd0, tc_ovf_cnt}, 32'd1);

    // Backpressure: 1, 2 accepted, 3 held until space frees
    out_ready = 1'b0; in_valid = 1'b1; in_addsub_sel = 1'b0; in_sum = 32'd1;
    tick();
    chk("bp1_in_ready", {31'd0, sm_in_ready}, 32'd1);
    chk("bp1_result", sm_out_result, 32'd1);
    in_sum = 32'd2;
    tick();
    chk("bp2_in_ready", {31'd0, sm_in_ready}, 32'd0);
    chk("bp2_result", sm_out_result, 32'd1);
    in_sum = 32'd3;
    tick();
    chk("bp3_in_ready", {31'd0, sm_in_ready}, 32'd0);
    chk("bp3_hold_result", sm_out_result, 32'd1);
    chk("bp3_hold_valid", {31'd0, sm_out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_result", sm_out_result, 32'd2);
    chk("bp_pop1_in_ready", {31'd0, sm_in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pop2_result", sm_out_result, 32'd3);
    chk("bp_pop2_valid", {31'd0, sm_out_valid}, 32'd1);
    tick();
    chk("bp_drain_valid", {31'd0, sm_out_valid}, 32'd0);
    chk("bp_res_cnt", {16'd0, sm_res_cnt}, 32'd5);
    $display("backpressure: res_cnt=%0d", sm_res_cnt);

    // Streaming push+pop every cycle while in ONE
    in_valid = 1'b1; in_sum = 32'd100;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_sum = 32'd200 + 32'(i);
      tick();
      chk("stream_result", sm_out_result, 32'd200 + 32'(i));
      chk("stream_in_ready", {31'd0, sm_in_ready}, 32'd1);
      $display("stream txn %0d result=%0d", i, sm_out_result);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_res_cnt", {16'd0, sm_res_cnt}, 32'd14);
    chk("stream_empty", {31'd0, sm_out_valid}, 32'd0);

    // Reset while FULL discards contents
    out_ready = 1'b0; in_valid = 1'b1; in_sum = 32'd7;
    tick();
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", {31'd0, sm_in_ready}, 32'd0);
    tb_ip_rst = 1'b1;
    tick();
    tb_ip_rst = 1'b0;
    chk("mrst_valid", {31'd0, sm_out_valid}, 32'd0);
    chk("mrst_res_cnt", {16'd0, sm_res_cnt}, 32'd0);
    chk("mrst_in_ready", {31'd0, sm_in_ready}, 32'd0);
    chk("mrst_result", sm_out_result, 32'd0);
    tick();
    chk("mrst_rel_in_ready", {31'd0, sm_in_ready}, 32'd1);
    chk("mrst_rel_valid", {31'd0, sm_out_valid}, 32'd0);
    $display("mid-op reset: valid=%0d res_cnt=%0d", sm_out_valid, sm_res_cnt);

    // Counter saturation then clear beating a simultaneous transfer
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 32'd0; in_addsub_sel = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      tick();
    end
    chk("cnt_max", {16'd0, sm_res_cnt}, 32'h0000_FFFF);
    tick();
    chk("cnt_hold", {16'd0, sm_res_cnt}, 32'h0000_FFFF);
    chk("cnt_ovf_none", {16'd0, sm_ovf_cnt}, 32'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr", {16'd0, sm_res_cnt}, 32'd0);
    chk("cnt_clr_valid", {31'd0, sm_out_valid}, 32'd1);
    $display("counter: after clear res_cnt=%0d", sm_res_cnt);
    tick();
    chk("cnt_after_clr", {16'd0, sm_res_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
